// File: rtl/seq_detect_311_pkg.sv
// Shared types, default constants and the saturating-increment helper
// for the seq_detect_311 serial pattern detector.
package seq_detect_311_pkg;

    localparam int PAT_W_DEF = 4;
    localparam int CNT_W_DEF = 8;

    typedef logic [PAT_W_DEF-1:0] pat_t;
    typedef logic [CNT_W_DEF-1:0] cnt_t;

    localparam pat_t DEF_PAT_DEF = 4'b1011;
    localparam cnt_t CNT_MAX_DEF = '1;

    // Width-agnostic: callers widen to 32 bits and truncate the result back.
    function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic [31:0] max_v);
        return (v >= max_v) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/sat_counter_311.sv
// CNT_W-bit saturating up-counter; synchronous clear wins over increment.
module sat_counter_311
    import seq_detect_311_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk_311,
    input  logic             rst_311,
    input  logic             i_inc,
    input  logic             i_clr,
    output logic [CNT_W-1:0] o_cnt
);

    localparam logic [31:0] MAX_V = 32'((64'd1 << CNT_W) - 64'd1);

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_inc;

    assign w_inc = CNT_W'(sat_inc(32'(r_cnt), MAX_V));

    always_ff @(posedge clk_311 or posedge rst_311) begin
        if (rst_311) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_inc) begin
            r_cnt <= w_inc;
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/seq_detect_311.sv
// Parametrised Mealy serial-sequence detector with run-time loadable pattern,
// overlap select and saturating match counter. Build with SEQ_DETECT_REG_OUT_EN
// defined to register match_311 (one cycle latency).
module seq_detect_311
    import seq_detect_311_pkg::*;
#(
    parameter int               PAT_W   = PAT_W_DEF,
    parameter logic [PAT_W-1:0] DEF_PAT = PAT_W'(DEF_PAT_DEF),
    parameter int               CNT_W   = CNT_W_DEF
) (
    input  logic             clk_311,
    input  logic             rst_311,
    input  logic             in_valid_311,
    input  logic             in_311,
    input  logic             pat_load_311,
    input  logic [PAT_W-1:0] pat_in_311,
    input  logic             overlap_311,
    input  logic             clr_cnt_311,
    output logic             match_311,
    output logic [CNT_W-1:0] match_cnt_311,
    output logic [PAT_W-1:0] pat_311
);

    localparam int               FILL_W   = $clog2(PAT_W);
    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_W - 1);

    logic [PAT_W-1:0]  r_pat;
    logic [PAT_W-2:0]  r_hist;
    logic [FILL_W-1:0] r_fill;

    logic [PAT_W-1:0]  w_pat_nxt;
    logic [PAT_W-2:0]  w_hist_nxt;
    logic [FILL_W-1:0] w_fill_nxt;
    logic [PAT_W-1:0]  w_window;
    logic              w_match;

    // The candidate window is the stored history plus the bit arriving now.
    assign w_window = {r_hist, in_311};
    assign w_match  = in_valid_311 & ~pat_load_311 & (r_fill == FILL_MAX)
                    & (w_window == r_pat);

    always_ff @(posedge clk_311 or posedge rst_311) begin
        if (rst_311) begin
            r_pat  <= DEF_PAT;
            r_hist <= '0;
            r_fill <= '0;
        end else begin
            r_pat  <= w_pat_nxt;
            r_hist <= w_hist_nxt;
            r_fill <= w_fill_nxt;
        end
    end

    always_comb begin
        w_pat_nxt  = r_pat;
        w_hist_nxt = r_hist;
        w_fill_nxt = r_fill;
        if (pat_load_311) begin
            w_pat_nxt  = pat_in_311;
            w_hist_nxt = '0;
            w_fill_nxt = '0;
        end else if (in_valid_311) begin
            // Non-overlapping mode forgets everything so the next hit needs PAT_W fresh bits.
            if (w_match && !overlap_311) begin
                w_hist_nxt = '0;
                w_fill_nxt = '0;
            end else begin
                w_hist_nxt = w_window[PAT_W-2:0];
                w_fill_nxt = (r_fill == FILL_MAX) ? r_fill : r_fill + FILL_W'(1);
            end
        end
    end

    sat_counter_311 #(
        .CNT_W (CNT_W)
    ) u_cnt (
        .clk_311 (clk_311),
        .rst_311 (rst_311),
        .i_inc   (w_match),
        .i_clr   (clr_cnt_311),
        .o_cnt   (match_cnt_311)
    );

`ifdef SEQ_DETECT_REG_OUT_EN
    logic r_match;

    always_ff @(posedge clk_311 or posedge rst_311) begin
        if (rst_311) begin
            r_match <= 1'b0;
        end else begin
            r_match <= w_match;
        end
    end

    assign match_311 = r_match;
`else
    assign match_311 = w_match;
`endif

    assign pat_311 = r_pat;

endmodule

// File: tb/tb_seq_detect_311.sv
// Scoreboard bench for seq_detect_311 (default build, counter width 2).
module tb_seq_detect_311;

    logic       clk_311 = 1'b0;
    logic       rst_311;
    logic       in_valid_311;
    logic       in_311;
    logic       pat_load_311;
    logic [3:0] pat_in_311;
    logic       overlap_311;
    logic       clr_cnt_311;
    logic       match_311;
    logic [1:0] match_cnt_311;
    logic [3:0] pat_311;

    int checks   = 0;
    int failures = 0;
    logic exp_q[$];

    seq_detect_311 #(
        .PAT_W   (4),
        .DEF_PAT (4'b1011),
        .CNT_W   (2)
    ) dut (
        .clk_311       (clk_311),
        .rst_311       (rst_311),
        .in_valid_311  (in_valid_311),
        .in_311        (in_311),
        .pat_load_311  (pat_load_311),
        .pat_in_311    (pat_in_311),
        .overlap_311   (overlap_311),
        .clr_cnt_311   (clr_cnt_311),
        .match_311     (match_311),
        .match_cnt_311 (match_cnt_311),
        .pat_311       (pat_311)
    );

    always #5 clk_311 = ~clk_311;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every presented sample pops one expected match value.
    always @(negedge clk_311) begin
        if (!rst_311) begin
            if (in_valid_311 && !pat_load_311) begin
                if (exp_q.size() == 0) begin
                    check("match_unexpected_sample", 32'(exp_q.size()), 32'd1);
                end else begin
                    check("match", 32'(match_311), 32'(exp_q.pop_front()));
                end
            end else begin
                check("match_idle", 32'(match_311), 32'd0);
            end
        end
    end

    task automatic send(input logic b, input logic exp, input logic clr = 1'b0);
        @(posedge clk_311); #1;
        in_valid_311 = 1'b1;
        in_311       = b;
        pat_load_311 = 1'b0;
        clr_cnt_311  = clr;
        exp_q.push_back(exp);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk_311); #1;
            in_valid_311 = 1'b0;
            pat_load_311 = 1'b0;
            clr_cnt_311  = 1'b0;
        end
    endtask

    // Load with a live sample present, which must be discarded.
    task automatic load(input logic [3:0] p);
        @(posedge clk_311); #1;
        pat_load_311 = 1'b1;
        pat_in_311   = p;
        in_valid_311 = 1'b1;
        in_311       = 1'b1;
        clr_cnt_311  = 1'b0;
    endtask

    task automatic clear_cnt();
        @(posedge clk_311); #1;
        in_valid_311 = 1'b0;
        pat_load_311 = 1'b0;
        clr_cnt_311  = 1'b1;
        idle(1);
        check("cnt_cleared", 32'(match_cnt_311), 32'd0);
    endtask

    task automatic send_seq(input logic [15:0] bits, input logic [15:0] exps, input int n);
        for (int i = n - 1; i >= 0; i--) send(bits[i], exps[i]);
    endtask

    initial begin
        rst_311      = 1'b1;
        in_valid_311 = 1'b0;
        in_311       = 1'b0;
        pat_load_311 = 1'b0;
        pat_in_311   = 4'b0000;
        overlap_311  = 1'b1;
        clr_cnt_311  = 1'b0;
        #2;
        check("rst_match", 32'(match_311), 32'd0);
        check("rst_cnt", 32'(match_cnt_311), 32'd0);
        check("rst_pat", 32'(pat_311), 32'hB);
        #10 rst_311 = 1'b0;

        // Overlapping: 1011011 hits on bits 4 and 7.
        overlap_311 = 1'b1;
        send_seq(16'b1011011, 16'b0001001, 7);
        idle(1);
        check("ovl_cnt", 32'(match_cnt_311), 32'd2);
        clear_cnt();

        // Non-overlapping: bit 7 no hit, then 1011 hits again.
        overlap_311 = 1'b0;
        load(4'b1011);
        send_seq(16'b10110111011, 16'b00010000001, 11);
        idle(1);
        check("novl_cnt", 32'(match_cnt_311), 32'd2);
        check("novl_pat", 32'(pat_311), 32'hB);
        clear_cnt();

        // Valid gaps hold the history.
        overlap_311 = 1'b1;
        load(4'b1011);
        send_seq(16'b10, 16'b00, 2);
        idle(3);
        send_seq(16'b11, 16'b01, 2);
        idle(1);
        check("gap_cnt", 32'(match_cnt_311), 32'd1);
        clear_cnt();

        // Load 0110 mid-stream discards the collected history.
        send_seq(16'b101, 16'b000, 3);
        load(4'b0110);
        idle(1);
        check("load_pat", 32'(pat_311), 32'h6);
        send_seq(16'b110, 16'b000, 3);
        send_seq(16'b0110, 16'b0001, 4);
        idle(1);
        check("load_cnt", 32'(match_cnt_311), 32'd1);
        clear_cnt();

        // Five overlapping 0110 hits: 2-bit count sticks at 3.
        send_seq(16'b0110110110110110, 16'b0001001001001001, 16);
        idle(1);
        check("sat_cnt", 32'(match_cnt_311), 32'd3);
        // Clear in the same cycle as a hit.
        send(1'b1, 1'b0);
        send(1'b1, 1'b0);
        send(1'b0, 1'b1, 1'b1);
        idle(1);
        check("clr_pri_cnt", 32'(match_cnt_311), 32'd0);

        // Async reset mid-pattern restores defaults between edges.
        send_seq(16'b110101, 16'b001000, 6);
        idle(1);
        check("pre_rst_cnt", 32'(match_cnt_311), 32'd1);
        #3 rst_311 = 1'b1;
        #1;
        check("arst_match", 32'(match_311), 32'd0);
        check("arst_cnt", 32'(match_cnt_311), 32'd0);
        check("arst_pat", 32'(pat_311), 32'hB);
        @(posedge clk_311); #2 rst_311 = 1'b0;
        send(1'b1, 1'b0);
        idle(2);
        check("post_rst_cnt", 32'(match_cnt_311), 32'd0);
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
